hash_job_controller: RTL and testbench
======================================

# hash_job_controller

Host-side sequencer that drives the SHA-256 core through a nonce sweep. Per nonce: resets the core, writes the nonce into the message buffer, pulses start, waits for done, reads back the 8-word digest from the output buffer and compares word 0 against a target. It sits beside the core on the shared word-addressed memory and owns the port whenever the core is held in reset.

## Interface
- NONCE_OFFSET, 19: word offset of the nonce within the message buffer.
- TIMEOUT_CYCLES, 1024: maximum cycles from core_start to core_done.
- clk  in  1  clock; also clocks the memory.
- reset_n  in  1  synchronous, active-low reset.
- job_start  in  1  start sweep; sampled in IDLE only.
- msg_addr, out_addr  in  16  message and digest base word addresses; latched at job_start.
- nonce_start, nonce_end  in  32  inclusive sweep bounds; latched at job_start.
- target  in  32  hit when digest word 0 < target (unsigned); latched.
- job_busy  out  1  high from the cycle after job_start until job_done.
- job_done  out  1  one-cycle pulse when the sweep ends.
- found  out  1  valid with job_done; held until the next job_start.
- found_nonce  out  32  nonce of the hit.
- found_hash  out  256  digest of the hit; word 0 in bits [255:224].
- timeout_err  out  1  sticky until the next job_start.
- core_rst_n  out  1  registered reset to the core; low for exactly 1 cycle per nonce.
- core_start  out  1  one-cycle start pulse to the core.
- core_done  in  1  core completion level.
- mem_sel  out  1  1 = controller owns memory; 0 = core owns it.
- mem_we  out  1  write enable.
- mem_addr  out  16  word address.
- mem_write_data  out  32  write data.
- mem_read_data  in  32  read data.

## Operation
- Reset values: job_busy, job_done, found, timeout_err, core_start, mem_we = 0; core_rst_n = 0; mem_sel = 1; found_nonce = 0; found_hash = 0; mem_addr = 0; mem_write_data = 0.
- States: IDLE, CORE_RST, WR_NONCE, START, RUN, RD, CHECK, NEXT, FINISH.
- IDLE: core_rst_n held low. On job_start: latch the inputs, set cur = nonce_start, clear found/timeout_err, go to CORE_RST.
- CORE_RST: core_rst_n = 0 for one cycle; mem_sel = 1.
- WR_NONCE: mem_we = 1, mem_addr = msg_addr + NONCE_OFFSET, mem_write_data = cur, core_rst_n = 1.
- START: mem_we = 0, mem_sel = 0, core_start = 1 for one cycle. Timeout counter cleared.
- RUN: wait for core_done; counter increments each cycle.
  - If core_done: mem_sel = 1, go to RD.
  - If counter reaches TIMEOUT_CYCLES first: timeout_err = 1, go to FINISH with found = 0.
- RD: issue mem_addr = out_addr + i for i = 0..7 on consecutive cycles. Read data for the address driven in cycle t is captured in cycle t+2, so RD lasts 10 cycles. Words are shifted into a 256-bit digest register.
- CHECK: if digest[255:224] < target, then found = 1, found_nonce = cur, found_hash = digest, go to FINISH. Otherwise go to NEXT.
- NEXT: if cur == nonce_end go to FINISH (found = 0). Otherwise cur = cur + 1 (mod 2^32), go to CORE_RST.
- FINISH: job_done pulse, job_busy = 0, core_rst_n = 0, return to IDLE.
- Sweep wrap-around: if nonce_end < nonce_start, cur wraps 0xFFFFFFFF -> 0x00000000 and continues to nonce_end. If nonce_start == nonce_end, exactly one nonce is tried.
- All address arithmetic is 16-bit modulo.
- job_start is ignored while job_busy.
- reset_n low mid-sweep: all state returns to reset values on the next edge; core_rst_n drops low; the sweep is abandoned with no job_done.

## Timing
- Per-nonce overhead outside RUN: CORE_RST 1 + WR_NONCE 1 + START 1 + RD 10 + CHECK 1 + NEXT 1 = 15 cycles.
- Latency from job_start to the first core_start: 3 cycles (job_start sampled at edge 0; core_start high after edge 3).
- job_done is asserted 2 cycles after CHECK on a hit. On a miss of the final nonce it is asserted 3 cycles after CHECK.
- mem_sel changes only on state entry. mem_we is never high while mem_sel = 0.

## Test plan
- Single nonce, hit: nonce_start = nonce_end = 5, core model returns word 0 = 0x00000010, target = 0x00000100. Required: one write of 5 to msg_addr+19; found = 1; found_nonce = 5; job_done pulses once.
- Miss then hit: range 0..3, digest word 0 < target only for nonce 2. Required: 3 core_start pulses; found_nonce = 2; nonce 3 never written.
- Exhausted with wrap: start 0xFFFFFFFE, end 0x00000001, never a hit. Required: writes of FFFFFFFE, FFFFFFFF, 0, 1; found = 0; job_done pulses once.
- Timeout: core_done is never asserted. Required: timeout_err = 1 exactly TIMEOUT_CYCLES cycles after core_start; job_done pulses; found = 0.
- Read alignment: memory holds 0x11111111..0x88888888 at out_addr..out_addr+7 with a hit. Required: found_hash = 0x11111111_22222222_..._88888888.
- Reset mid-RUN: reset_n low for 1 cycle during RUN. Required: all outputs at reset values after the next edge, no job_done, and a new job_start is accepted normally.

Source files
------------

// File: rtl/hash_job_controller.sv
// Nonce-sweep sequencer for the SHA-256 core: per nonce it resets the core, writes the
// nonce, starts the core, reads back the digest and compares word 0 against a target.
module hash_job_controller #(
  parameter int NONCE_OFFSET   = 19,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         job_start,
  input  logic [15:0]  msg_addr,
  input  logic [15:0]  out_addr,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [31:0]  target,
  output logic         job_busy,
  output logic         job_done,
  output logic         found,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic         timeout_err,
  output logic         core_rst_n,
  output logic         core_start,
  input  logic         core_done,
  output logic         mem_sel,
  output logic         mem_we,
  output logic [15:0]  mem_addr,
  output logic [31:0]  mem_write_data,
  input  logic [31:0]  mem_read_data
);

  localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]   OFF    = 16'(NONCE_OFFSET);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CORE_RST,
    S_WR_NONCE,
    S_START,
    S_RUN,
    S_RD,
    S_CHECK,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t         state_reg;
  logic [15:0]    msg_addr_reg;
  logic [15:0]    out_addr_reg;
  logic [31:0]    nonce_end_reg;
  logic [31:0]    target_reg;
  logic [31:0]    cur_reg;
  logic [TW-1:0]  tcnt_reg;
  logic [3:0]     rd_idx_reg;
  logic [255:0]   digest_reg;

  // Outputs are registered from the state being executed, so every output trails its
  // state by one cycle; the read pipeline below is aligned to that.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      msg_addr_reg   <= '0;
      out_addr_reg   <= '0;
      nonce_end_reg  <= '0;
      target_reg     <= '0;
      cur_reg        <= '0;
      tcnt_reg       <= '0;
      rd_idx_reg     <= '0;
      digest_reg     <= '0;
      job_busy       <= 1'b0;
      job_done       <= 1'b0;
      found          <= 1'b0;
      found_nonce    <= '0;
      found_hash     <= '0;
      timeout_err    <= 1'b0;
      core_rst_n     <= 1'b0;
      core_start     <= 1'b0;
      mem_sel        <= 1'b1;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      job_done   <= 1'b0;
      core_start <= 1'b0;
      unique case (state_reg)
        S_IDLE: begin
          core_rst_n <= 1'b0;
          mem_sel    <= 1'b1;
          mem_we     <= 1'b0;
          if (job_start) begin
            msg_addr_reg  <= msg_addr;
            out_addr_reg  <= out_addr;
            nonce_end_reg <= nonce_end;
            target_reg    <= target;
            cur_reg       <= nonce_start;
            found         <= 1'b0;
            timeout_err   <= 1'b0;
            job_busy      <= 1'b1;
            state_reg     <= S_CORE_RST;
          end
        end
        S_CORE_RST: begin
          core_rst_n <= 1'b0;
          mem_sel    <= 1'b1;
          mem_we     <= 1'b0;
          state_reg  <= S_WR_NONCE;
        end
        S_WR_NONCE: begin
          mem_we         <= 1'b1;
          mem_addr       <= msg_addr_reg + OFF;
          mem_write_data <= cur_reg;
          core_rst_n     <= 1'b1;
          state_reg      <= S_START;
        end
        S_START: begin
          mem_we     <= 1'b0;
          mem_sel    <= 1'b0;
          core_start <= 1'b1;
          tcnt_reg   <= '0;
          state_reg  <= S_RUN;
        end
        S_RUN: begin
          if (core_done) begin
            mem_sel    <= 1'b1;
            rd_idx_reg <= '0;
            state_reg  <= S_RD;
          end else if (tcnt_reg == T_LAST) begin
            timeout_err <= 1'b1;
            found       <= 1'b0;
            state_reg   <= S_FINISH;
          end else begin
            tcnt_reg <= tcnt_reg + 1'b1;
          end
        end
        S_RD: begin
          // Addresses go out on steps 0..7; the memory answers two steps later.
          if (rd_idx_reg < 4'd8) begin
            mem_addr <= out_addr_reg + {12'd0, rd_idx_reg};
          end
          if (rd_idx_reg >= 4'd2) begin
            digest_reg <= {digest_reg[223:0], mem_read_data};
          end
          rd_idx_reg <= rd_idx_reg + 4'd1;
          if (rd_idx_reg == 4'd9) begin
            state_reg <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (digest_reg[255:224] < target_reg) begin
            found       <= 1'b1;
            found_nonce <= cur_reg;
            found_hash  <= digest_reg;
            state_reg   <= S_FINISH;
          end else begin
            state_reg <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (cur_reg == nonce_end_reg) begin
            found     <= 1'b0;
            state_reg <= S_FINISH;
          end else begin
            cur_reg   <= cur_reg + 32'd1;
            state_reg <= S_CORE_RST;
          end
        end
        S_FINISH: begin
          job_done   <= 1'b1;
          job_busy   <= 1'b0;
          core_rst_n <= 1'b0;
          mem_sel    <= 1'b1;
          mem_we     <= 1'b0;
          state_reg  <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_job_controller.sv
// Bench for hash_job_controller: behavioural core + memory, and a sweep model that
// predicts written nonces, hit/miss, digest and pulse timing for each job.
module tb_hash_job_controller;

  localparam int TO = 1024;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         job_start;
  logic [15:0]  msg_addr, out_addr;
  logic [31:0]  nonce_start, nonce_end, target;
  logic         job_busy, job_done, found, timeout_err;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
  logic         core_rst_n, core_start;
  logic         core_done = 1'b0;
  logic         mem_sel, mem_we;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_write_data;
  logic [31:0]  mem_read_data;

  always #5 clk = ~clk;

  hash_job_controller dut (
    .clk(clk), .reset_n(reset_n), .job_start(job_start),
    .msg_addr(msg_addr), .out_addr(out_addr),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
    .job_busy(job_busy), .job_done(job_done), .found(found),
    .found_nonce(found_nonce), .found_hash(found_hash), .timeout_err(timeout_err),
    .core_rst_n(core_rst_n), .core_start(core_start), .core_done(core_done),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // current job
  logic [15:0] j_msg, j_out, exp_waddr;
  logic [31:0] j_ns, j_ne, j_tgt, seed;
  int          lat = 1;
  bit          no_done = 1'b0, pat_mode = 1'b0, force_en = 1'b0;
  logic [31:0] force_nonce, force_val;

  // model outputs
  logic [31:0]  exp_writes[$];
  bit           exp_found, exp_timeout;
  logic [31:0]  exp_nonce;
  logic [255:0] exp_hash;
  int           exp_starts, exp_dly;

  // monitor state
  bit  job_active = 1'b0;
  bit  prev_to = 1'b0;
  int  js = 0, last_start = 0, n_starts = 0, wr_idx = 0, done_cnt = 0, job_no = 0;

  logic [31:0] mem [0:65535];
  int rem = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    else passes++;
  endtask

  function automatic logic [31:0] dword(input logic [31:0] n, input int i);
    logic [31:0] w;
    if (pat_mode) return 32'h11111111 * 32'(i + 1);
    w = (n ^ seed) * 32'h9E3779B1;
    w = w ^ (w >> 13) ^ (32'(i) * 32'h85EBCA77);
    w = w * 32'hC2B2AE35;
    w = w ^ (w >> 16);
    if (i == 0 && force_en) return (n == force_nonce) ? force_val : (w | 32'h1000_0000);
    return w;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Shared memory plus a behavioural core that posts its digest when it finishes.
  always @(posedge clk) begin
    mem_read_data <= mem[mem_addr];
    if (mem_sel && mem_we) mem[mem_addr] <= mem_write_data;
    if (!core_rst_n) begin
      core_done <= 1'b0;
      rem       <= 0;
    end else if (core_start) begin
      if (no_done) rem <= 0;
      else if (lat == 1) begin
        core_done <= 1'b1;
        for (int i = 0; i < 8; i++) mem[j_out + 16'(i)] <= dword(mem[j_msg + 16'd19], i);
      end else rem <= lat - 1;
    end else if (rem != 0) begin
      rem <= rem - 1;
      if (rem == 1) begin
        core_done <= 1'b1;
        for (int i = 0; i < 8; i++) mem[j_out + 16'(i)] <= dword(mem[j_msg + 16'd19], i);
      end
    end
  end

  // Sweep model: walks the nonce range the way the job is defined to.
  task automatic build_model();
    logic [31:0]  n;
    logic [255:0] h;
    n = j_ns;
    exp_writes.delete();
    exp_found = 0; exp_timeout = 0; exp_starts = 0; exp_nonce = '0; exp_hash = '0;
    while (1) begin
      exp_writes.push_back(n);
      exp_starts++;
      if (no_done) begin exp_timeout = 1; exp_dly = TO + 1; break; end
      for (int i = 0; i < 8; i++) h[255 - 32*i -: 32] = dword(n, i);
      if (h[255:224] < j_tgt) begin
        exp_found = 1; exp_nonce = n; exp_hash = h; exp_dly = lat + 13; break;
      end
      if (n == j_ne) begin exp_dly = lat + 14; break; end
      n = n + 32'd1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (job_active && cyc == js) begin
          check("busy_at_start", 256'(job_busy), 256'(1));
          check("found_cleared", 256'(found), 256'(0));
          check("timeout_cleared", 256'(timeout_err), 256'(0));
        end
        if (mem_we) begin
          check("we_owner", 256'(mem_sel), 256'(1));
          if (wr_idx < exp_writes.size()) begin
            check("wr_addr", 256'(mem_addr), 256'(exp_waddr));
            check("wr_data", 256'(mem_write_data), 256'(exp_writes[wr_idx]));
          end else check("wr_extra", 256'(wr_idx), 256'(exp_writes.size()));
          wr_idx++;
        end
        if (core_start) begin
          if (n_starts == 0) check("first_start_lat", 256'(cyc - js), 256'(3));
          else check("start_gap", 256'(cyc - last_start), 256'(lat + 16));
          last_start = cyc;
          n_starts++;
        end
        if (timeout_err && !prev_to) check("timeout_delay", 256'(cyc - last_start), 256'(TO));
        prev_to = timeout_err;
        if (job_done) begin
          if (!job_active) check("unexpected_done", 256'(job_active), 256'(1));
          else begin
            check("done_delay", 256'(cyc - last_start), 256'(exp_dly));
            check("busy_at_done", 256'(job_busy), 256'(0));
            check("found", 256'(found), 256'(exp_found));
            check("timeout_err", 256'(timeout_err), 256'(exp_timeout));
            check("starts", 256'(n_starts), 256'(exp_starts));
            check("writes", 256'(wr_idx), 256'(exp_writes.size()));
            if (exp_found) begin
              check("found_nonce", 256'(found_nonce), 256'(exp_nonce));
              check("found_hash", found_hash, exp_hash);
            end
            $display("job %0d: range %h..%h tgt %h found=%0d nonce=%h timeout=%0d starts=%0d",
                     job_no, j_ns, j_ne, j_tgt, found, found_nonce, timeout_err, n_starts);
          end
          job_active = 0;
          done_cnt++;
        end
      end
    end
  end

  task automatic start_job(input logic [15:0] m, input logic [15:0] o, input logic [31:0] ns,
                           input logic [31:0] ne, input logic [31:0] tg, input int l, input bit nd);
    j_msg = m; j_out = o; j_ns = ns; j_ne = ne; j_tgt = tg; lat = l; no_done = nd;
    build_model();
    exp_waddr = m + 16'd19;
    wr_idx = 0; n_starts = 0; job_no++;
    @(posedge clk); #1;
    msg_addr = m; out_addr = o; nonce_start = ns; nonce_end = ne; target = tg;
    job_start = 1'b1; js = cyc + 1; job_active = 1;
    @(posedge clk); #1;
    job_start = 1'b0;
    msg_addr = 16'($urandom); out_addr = 16'($urandom);
    nonce_start = $urandom; nonce_end = $urandom; target = $urandom;
  endtask

  task automatic wait_done(input int budget);
    int t0;
    t0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == t0; i++) @(posedge clk);
    check("done_within_budget", 256'(done_cnt != t0), 256'(1));
    repeat (4) @(posedge clk);
    #1;
    check("done_once", 256'(done_cnt), 256'(t0 + 1));
    check("found_held", 256'(found), 256'(exp_found));
  endtask

  task automatic check_reset_vals();
    check("rst_busy", 256'(job_busy), 256'(0));
    check("rst_done", 256'(job_done), 256'(0));
    check("rst_found", 256'(found), 256'(0));
    check("rst_timeout", 256'(timeout_err), 256'(0));
    check("rst_core_start", 256'(core_start), 256'(0));
    check("rst_we", 256'(mem_we), 256'(0));
    check("rst_core_rst_n", 256'(core_rst_n), 256'(0));
    check("rst_mem_sel", 256'(mem_sel), 256'(1));
    check("rst_found_nonce", 256'(found_nonce), 256'(0));
    check("rst_found_hash", found_hash, 256'(0));
    check("rst_mem_addr", 256'(mem_addr), 256'(0));
    check("rst_wdata", 256'(mem_write_data), 256'(0));
  endtask

  initial begin
    int t0, len;
    for (int a = 0; a < 65536; a++) mem[a] = '0;
    reset_n = 1'b0; job_start = 1'b0;
    msg_addr = '0; out_addr = '0; nonce_start = '0; nonce_end = '0; target = '0;
    seed = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    reset_n = 1'b1;

    // single nonce, hit
    force_en = 1; force_nonce = 32'd5; force_val = 32'h10;
    start_job(16'h0100, 16'h0200, 32'd5, 32'd5, 32'h100, 3, 0);
    wait_done(300);
    check("lit_single_found", 256'(found), 256'(1));
    check("lit_single_nonce", 256'(found_nonce), 256'(5));
    check("lit_single_writes", 256'(wr_idx), 256'(1));

    // miss then hit on nonce 2
    force_nonce = 32'd2;
    start_job(16'h1000, 16'h2000, 32'd0, 32'd3, 32'h100, 5, 0);
    wait_done(400);
    check("lit_mh_starts", 256'(n_starts), 256'(3));
    check("lit_mh_nonce", 256'(found_nonce), 256'(2));
    check("lit_mh_writes", 256'(wr_idx), 256'(3));

    // exhausted sweep across the 32-bit wrap
    force_en = 0;
    start_job(16'h3000, 16'h3010, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0, 2, 0);
    check("lit_model_wrap", 256'(exp_writes[2]), 256'(0));
    wait_done(400);
    check("lit_wrap_starts", 256'(n_starts), 256'(4));
    check("lit_wrap_found", 256'(found), 256'(0));

    // core never finishes
    start_job(16'h0040, 16'h0080, 32'd4, 32'd4, 32'hFFFF_FFFF, 1, 1);
    wait_done(TO + 200);
    check("lit_timeout_err", 256'(timeout_err), 256'(1));

    // read alignment, with 16-bit address wrap on both buffers
    pat_mode = 1;
    start_job(16'hFFF0, 16'hFFFC, 32'd7, 32'd9, 32'hFFFF_FFFF, 4, 0);
    wait_done(300);
    check("lit_align_hash", found_hash,
          256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888);
    check("lit_align_nonce", 256'(found_nonce), 256'(7));
    pat_mode = 0;

    // reset while the core is running
    start_job(16'h4000, 16'h5000, 32'd100, 32'd100, 32'h0, 40, 0);
    for (int i = 0; i < 50 && n_starts == 0; i++) @(posedge clk);
    check("reset_test_started", 256'(n_starts), 256'(1));
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0; job_active = 0;
    t0 = done_cnt;
    @(posedge clk); #1;
    check_reset_vals();
    reset_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    check("no_done_after_reset", 256'(done_cnt), 256'(t0));

    // randomized jobs
    for (int k = 0; k < 8; k++) begin
      logic [31:0] ns;
      logic [31:0] tg;
      seed = $urandom;
      len = int'($urandom_range(1, 5));
      ns = (k == 3) ? 32'hFFFF_FFFD : $urandom;
      force_en = $urandom_range(0, 1) == 1;
      if (force_en) begin
        force_nonce = ns + 32'($urandom_range(0, len - 1));
        force_val = 32'($urandom_range(0, 255));
        tg = 32'h100;
      end else begin
        case ($urandom_range(0, 2))
          0: tg = $urandom;
          1: tg = 32'h2000_0000;
          default: tg = 32'h0;
        endcase
      end
      start_job(16'($urandom), 16'($urandom), ns, ns + 32'(len - 1), tg,
                int'($urandom_range(1, 20)), 0);
      if (k % 2 == 1) begin
        for (int i = 0; i < 50 && n_starts == 0; i++) @(posedge clk);
        #1;
        nonce_start = $urandom; job_start = 1'b1;
        @(posedge clk); #1;
        job_start = 1'b0;
      end
      wait_done(1000);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
